// File: rtl/branch_direction_predictor.sv
// Saturating-counter direction predictor (bimodal or gshare), trained by execute; table swept to init after reset.
// Lookup latency 1 cycle; stall holds the prediction registers, flush clears predictValid.
module branch_direction_predictor #(
    parameter int PC_WIDTH      = 32,
    parameter int INDEX_WIDTH   = 8,
    parameter int HISTORY_WIDTH = 8,
    parameter int COUNTER_WIDTH = 2,
    parameter int MODE          = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetchValid,
    input  logic [PC_WIDTH-1:0]    fetchPc,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   predictValid,
    output logic                   predictTaken,
    output logic [INDEX_WIDTH-1:0] predictIndex,
    input  logic                   exIsBranch,
    input  logic                   exIsBranchTaken,
    input  logic [INDEX_WIDTH-1:0] exIndex,
    output logic                   ready
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam logic [COUNTER_WIDTH-1:0] CNT_INIT = COUNTER_WIDTH'((1 << (COUNTER_WIDTH - 1)) - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = {COUNTER_WIDTH{1'b1}};

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [INDEX_WIDTH-1:0]   r_sweep_ptr;
    logic [INDEX_WIDTH-1:0]   w_sweep_nxt;
    logic [HISTORY_WIDTH-1:0] r_ghr;
    logic [HISTORY_WIDTH-1:0] w_ghr_shift;
    logic [COUNTER_WIDTH-1:0] r_table [ENTRIES];

    logic                     r_pred_vld;
    logic                     r_pred_taken;
    logic [INDEX_WIDTH-1:0]   r_pred_idx;

    logic [INDEX_WIDTH-1:0]   w_pc_idx;
    logic [INDEX_WIDTH-1:0]   w_lookup_idx;
    logic [COUNTER_WIDTH-1:0] w_lookup_cnt;
    logic [COUNTER_WIDTH-1:0] w_train_cnt;
    logic [COUNTER_WIDTH-1:0] w_train_nxt;
    logic                     w_train_en;
    logic                     w_table_we;
    logic [INDEX_WIDTH-1:0]   w_table_waddr;
    logic [COUNTER_WIDTH-1:0] w_table_wdat;
    logic                     w_unused_pc;

    assign w_unused_pc  = ^fetchPc;
    assign w_pc_idx     = fetchPc[INDEX_WIDTH+1:2];
    // History sits in the low index bits; lookups always see the pre-update ghr.
    assign w_lookup_idx = (MODE == 0) ? w_pc_idx : (w_pc_idx ^ INDEX_WIDTH'(r_ghr));
    assign w_lookup_cnt = r_table[w_lookup_idx];
    assign w_train_cnt  = r_table[exIndex];

    always_comb begin
        w_train_nxt = w_train_cnt;
        if (exIsBranchTaken) begin
            if (w_train_cnt != CNT_MAX) w_train_nxt = w_train_cnt + 1'b1;
        end else begin
            if (w_train_cnt != '0) w_train_nxt = w_train_cnt - 1'b1;
        end
    end

    generate
        if (HISTORY_WIDTH == 1) begin : g_ghr_one
            assign w_ghr_shift = exIsBranchTaken;
        end else begin : g_ghr_wide
            assign w_ghr_shift = {r_ghr[HISTORY_WIDTH-2:0], exIsBranchTaken};
        end
    endgenerate

    always_comb begin
        w_state_nxt   = r_state;
        w_sweep_nxt   = r_sweep_ptr;
        w_train_en    = 1'b0;
        w_table_we    = 1'b0;
        w_table_waddr = exIndex;
        w_table_wdat  = w_train_nxt;
        case (r_state)
            S_INIT: begin
                w_table_we    = 1'b1;
                w_table_waddr = r_sweep_ptr;
                w_table_wdat  = CNT_INIT;
                w_sweep_nxt   = r_sweep_ptr + 1'b1;
                if (r_sweep_ptr == {INDEX_WIDTH{1'b1}}) w_state_nxt = S_READY;
            end
            S_READY: begin
                w_train_en = exIsBranch;
                w_table_we = exIsBranch;
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_INIT;
            r_sweep_ptr  <= '0;
            r_ghr        <= '0;
            r_pred_vld   <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_idx   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_ptr <= w_sweep_nxt;
            if (w_train_en) r_ghr <= w_ghr_shift;
            if (flush) begin
                r_pred_vld <= 1'b0;
            end else if (!stall) begin
                r_pred_vld <= fetchValid;
                if (fetchValid) begin
                    r_pred_taken <= (r_state == S_READY) && w_lookup_cnt[COUNTER_WIDTH-1];
                    r_pred_idx   <= w_lookup_idx;
                end
            end
        end
    end

    // Counter storage carries no reset; the post-reset sweep defines every entry.
    always_ff @(posedge clk) begin
        if (w_table_we) r_table[w_table_waddr] <= w_table_wdat;
    end

    assign predictValid = r_pred_vld;
    assign predictTaken = r_pred_taken;
    assign predictIndex = r_pred_idx;
    assign ready        = (r_state == S_READY);

endmodule

// File: tb/tb_branch_direction_predictor.sv
// Bimodal (16 entries) and gshare (256 entries, 2-bit history) predictors checked against an array model.
module tb_branch_direction_predictor;

    logic        clk = 1'b0;
    logic        rst, fv, stall, flush, exb, ext;
    logic [31:0] pc;
    logic [3:0]  ex_b;
    logic [7:0]  ex_g;
    logic        b_vld, b_tkn, b_rdy, g_vld, g_tkn, g_rdy;
    logic [3:0]  b_idx;
    logic [7:0]  g_idx;

    int m_tbl [2][256];
    int m_ghr [2];
    int m_since [2];
    int m_vld [2];
    int m_tkn [2];
    int m_idx [2];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    branch_direction_predictor #(
        .PC_WIDTH(32), .INDEX_WIDTH(4), .HISTORY_WIDTH(4), .COUNTER_WIDTH(2), .MODE(0)
    ) u_bim (
        .clk(clk), .rst(rst), .fetchValid(fv), .fetchPc(pc), .stall(stall), .flush(flush),
        .predictValid(b_vld), .predictTaken(b_tkn), .predictIndex(b_idx),
        .exIsBranch(exb), .exIsBranchTaken(ext), .exIndex(ex_b), .ready(b_rdy)
    );

    branch_direction_predictor #(
        .PC_WIDTH(32), .INDEX_WIDTH(8), .HISTORY_WIDTH(2), .COUNTER_WIDTH(2), .MODE(1)
    ) u_gsh (
        .clk(clk), .rst(rst), .fetchValid(fv), .fetchPc(pc), .stall(stall), .flush(flush),
        .predictValid(g_vld), .predictTaken(g_tkn), .predictIndex(g_idx),
        .exIsBranch(exb), .exIsBranchTaken(ext), .exIndex(ex_g), .ready(g_rdy)
    );

    function automatic int iw_of(input int d);
        return (d == 1) ? 8 : 4;
    endfunction

    function automatic int hw_of(input int d);
        return (d == 1) ? 2 : 4;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counters as plain integers 0..3, readiness as cycles since reset.
    always @(posedge clk or negedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                m_ghr[d]   = 0;
                m_since[d] = 0;
                m_vld[d]   = 0;
                m_tkn[d]   = 0;
                m_idx[d]   = 0;
                for (int e = 0; e < 256; e++) m_tbl[d][e] = 1;
            end else begin
                automatic int  size   = 1 << iw_of(d);
                automatic bit  is_rdy = (m_since[d] >= size);
                automatic int  idx    = (int'(pc[31:2]) & (size - 1)) ^ ((d == 1) ? m_ghr[d] : 0);
                automatic int  ex     = (d == 1) ? int'(ex_g) : int'(ex_b);
                if (flush) begin
                    m_vld[d] = 0;
                end else if (!stall) begin
                    m_vld[d] = fv ? 1 : 0;
                    if (fv) begin
                        m_tkn[d] = (is_rdy && m_tbl[d][idx] >= 2) ? 1 : 0;
                        m_idx[d] = idx;
                    end
                end
                if (is_rdy && exb) begin
                    if (ext) m_tbl[d][ex] = (m_tbl[d][ex] == 3) ? 3 : m_tbl[d][ex] + 1;
                    else     m_tbl[d][ex] = (m_tbl[d][ex] == 0) ? 0 : m_tbl[d][ex] - 1;
                    m_ghr[d] = ((m_ghr[d] << 1) | (ext ? 1 : 0)) % (1 << hw_of(d));
                end
                if (!is_rdy) m_since[d]++;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_b_vld", int'(b_vld), m_vld[0]);
        chk("model_g_vld", int'(g_vld), m_vld[1]);
        if (m_vld[0] != 0) begin
            chk("model_b_tkn", int'(b_tkn), m_tkn[0]);
            chk("model_b_idx", int'(b_idx), m_idx[0]);
        end
        if (m_vld[1] != 0) begin
            chk("model_g_tkn", int'(g_tkn), m_tkn[1]);
            chk("model_g_idx", int'(g_idx), m_idx[1]);
        end
        chk("model_b_rdy", int'(b_rdy), (m_since[0] >= 16) ? 1 : 0);
        chk("model_g_rdy", int'(g_rdy), (m_since[1] >= 256) ? 1 : 0);
    end

    task automatic cyc(input logic f, input logic [31:0] p, input logic e, input logic t,
                       input logic [3:0] eb, input logic [7:0] eg,
                       input logic s = 1'b0, input logic fl = 1'b0);
        fv = f; pc = p; exb = e; ext = t; ex_b = eb; ex_g = eg; stall = s; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 8'h0);
    endtask

    task automatic look(input logic [31:0] p);
        cyc(1'b1, p, 1'b0, 1'b0, 4'h0, 8'h0);
    endtask

    task automatic train(input logic t, input logic [3:0] eb, input logic [7:0] eg);
        cyc(1'b0, 32'h0, 1'b1, t, eb, eg);
    endtask

    initial begin
        rst = 1'b0; fv = 1'b0; pc = '0; stall = 1'b0; flush = 1'b0;
        exb = 1'b0; ext = 1'b0; ex_b = '0; ex_g = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_b_vld", int'(b_vld), 0);
        chk("rst_b_idx", int'(b_idx), 0);
        chk("rst_b_rdy", int'(b_rdy), 0);
        chk("rst_g_rdy", int'(g_rdy), 0);
        rst = 1'b1;

        for (int k = 0; k < 16; k++) begin
            if (k == 1)      look(32'h40);
            else if (k == 3) train(1'b1, 4'hF, 8'hF0);
            else             idle();
            if (k == 1) begin
                chk("init_b_vld", int'(b_vld), 1);
                chk("init_b_tkn", int'(b_tkn), 0);
                chk("init_g_idx", int'(g_idx), 8'h10);
            end
            chk("init_b_rdy", int'(b_rdy), (k == 15) ? 1 : 0);
        end
        for (int k = 16; k < 256; k++) begin
            idle();
            if (k == 254) chk("init_g_rdy_lo", int'(g_rdy), 0);
            if (k == 255) chk("init_g_rdy_hi", int'(g_rdy), 1);
        end

        look(32'h40);
        chk("gs_idx_ghr0", int'(g_idx), 8'h10);
        chk("gs_tkn_ghr0", int'(g_tkn), 0);
        train(1'b1, 4'hF, 8'hF0);
        train(1'b0, 4'hF, 8'hF0);
        look(32'h40);
        chk("gs_idx_ghr2", int'(g_idx), 8'h12);
        train(1'b1, 4'hF, 8'h12);
        train(1'b1, 4'hF, 8'h12);
        look(32'h4C);
        chk("gs_alias_idx", int'(g_idx), 8'h10);
        chk("gs_alias_tkn", int'(g_tkn), 0);
        look(32'h44);
        chk("gs_trained_idx", int'(g_idx), 8'h12);
        chk("gs_trained_tkn", int'(g_tkn), 1);

        look(32'h40);
        chk("bim_before", int'(b_tkn), 0);
        train(1'b1, 4'h0, 8'hFF);
        look(32'h40);
        chk("bim_after1", int'(b_tkn), 1);
        repeat (6) train(1'b1, 4'h0, 8'hFF);
        train(1'b0, 4'h0, 8'hFF);
        look(32'h40);
        chk("bim_hyst", int'(b_tkn), 1);

        repeat (4) train(1'b0, 4'h3, 8'hFF);
        look(32'h0C);
        chk("sat_zero", int'(b_tkn), 0);
        train(1'b1, 4'h3, 8'hFF);
        look(32'h0C);
        chk("sat_one_up", int'(b_tkn), 0);
        train(1'b1, 4'h3, 8'hFF);
        look(32'h0C);
        chk("sat_two_up", int'(b_tkn), 1);

        cyc(1'b1, 32'h14, 1'b1, 1'b1, 4'h5, 8'hFF);
        chk("same_cyc_tkn", int'(b_tkn), 0);
        chk("same_cyc_idx", int'(b_idx), 5);
        look(32'h14);
        chk("same_cyc_next", int'(b_tkn), 1);

        look(32'h14);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h0C, 1'b0, 1'b0, 4'h0, 8'h0, 1'b1, 1'b0);
            chk("stall_vld", int'(b_vld), 1);
            chk("stall_tkn", int'(b_tkn), 1);
            chk("stall_idx", int'(b_idx), 5);
        end
        cyc(1'b1, 32'h14, 1'b0, 1'b0, 4'h0, 8'h0, 1'b0, 1'b1);
        chk("flush_b_vld", int'(b_vld), 0);
        chk("flush_g_vld", int'(g_vld), 0);
        look(32'h14);
        cyc(1'b1, 32'h14, 1'b0, 1'b0, 4'h0, 8'h0, 1'b1, 1'b1);
        chk("flush_stall_vld", int'(b_vld), 0);
        look(32'h14);
        idle();
        chk("idle_vld", int'(b_vld), 0);

        repeat (3000) begin
            cyc(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
        end

        rst = 1'b0;
        idle();
        rst = 1'b1;
        repeat (9) idle();
        rst = 1'b0;
        idle();
        chk("midsweep_rdy_rst", int'(b_rdy), 0);
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            idle();
            chk("midsweep_rdy", int'(b_rdy), (k == 15) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
